// File: rtl/lane_flag_reader.sv
// -----------------------------------------------------------------------------
// lane_flag_reader
//
// Read side for replicated per-lane writers. Each lane k posts a payload with a
// one-cycle pulse on set_i[k]. The payload goes into a per-lane holding
// register and is marked pending. A round-robin scanner moves pending lanes,
// one at a time, onto a single valid/ready output stream.
//
// Output handshake: an entry is offered while out_valid_o is high. It is
// transferred on the rising edge where out_valid_o and out_ready_i are both
// high. out_lane_o and out_data_o hold steady from the cycle out_valid_o rises
// until that transfer. out_ready_i is ignored while out_valid_o is low.
//
// Ports
//   clk          in   1                 clock, all state on rising edge
//   rst_n        in   1                 asynchronous active-low reset
//   set_i        in   LANES             per-lane post pulse
//   set_data_i   in   LANES*PAYLOAD_W   lane k payload at [k*PAYLOAD_W +: PAYLOAD_W]
//   out_valid_o  out  1                 output entry valid
//   out_ready_i  in   1                 downstream accept
//   out_lane_o   out  IDX_W             lane index of presented entry
//   out_data_o   out  PAYLOAD_W         payload of presented entry
//   pending_o    out  LANES             per-lane holding register occupied
//   overflow_o   out  LANES             sticky: lane posted while already pending
//   clr_ovf_i    in   1                 clears all overflow bits
//   state_o      out  1                 scanner FSM state (0 = IDLE, 1 = PRESENT)
// -----------------------------------------------------------------------------
module lane_flag_reader #(
  parameter int LANES     = 4,
  parameter int PAYLOAD_W = 8,
  localparam int IDX_W    = $clog2(LANES)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [LANES-1:0]           set_i,
  input  logic [LANES*PAYLOAD_W-1:0] set_data_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [IDX_W-1:0]           out_lane_o,
  output logic [PAYLOAD_W-1:0]       out_data_o,
  output logic [LANES-1:0]           pending_o,
  output logic [LANES-1:0]           overflow_o,
  input  logic                       clr_ovf_i,
  output logic [0:0]                 state_o
);

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_PRESENT = 1'b1;

  logic [0:0]           state_q;
  logic [IDX_W-1:0]     ptr_q;
  logic [IDX_W-1:0]     lane_q;
  logic [PAYLOAD_W-1:0] data_q;

  logic [LANES-1:0]     pending_q;
  logic [LANES-1:0]     overflow_q;
  logic [PAYLOAD_W-1:0] hold_q [LANES];

  // One-hot: the lane whose holding register is moved to the output this cycle.
  logic [LANES-1:0]     load_vec;

  logic                 sel_found;
  logic [IDX_W-1:0]     sel_idx;
  logic [IDX_W:0]       cand;
  logic [IDX_W-1:0]     ptr_inc;

  // ---------------------------------------------------------------------------
  // Per-lane holding registers
  // ---------------------------------------------------------------------------
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic                 lane_pend;
    logic                 lane_ovf;
    logic [PAYLOAD_W-1:0] lane_hold;
    logic [PAYLOAD_W-1:0] lane_payload;

    assign lane_payload = set_data_i[k*PAYLOAD_W +: PAYLOAD_W];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        lane_pend <= 1'b0;
        lane_ovf  <= 1'b0;
        lane_hold <= '0;
      end else begin
        // A load in the same cycle reads the old value (non-blocking), so the
        // new payload is captured without losing the one going out.
        if (set_i[k]) begin
          lane_hold <= lane_payload;
        end

        if (set_i[k]) begin
          lane_pend <= 1'b1;
        end else if (load_vec[k]) begin
          lane_pend <= 1'b0;
        end

        // Overwriting an entry that nobody has taken is the only way data is
        // lost. A fresh overflow event beats a simultaneous clear.
        if (set_i[k] && lane_pend && !load_vec[k]) begin
          lane_ovf <= 1'b1;
        end else if (clr_ovf_i) begin
          lane_ovf <= 1'b0;
        end
      end
    end

    assign pending_q[k]  = lane_pend;
    assign overflow_q[k] = lane_ovf;
    assign hold_q[k]     = lane_hold;
  end

  // ---------------------------------------------------------------------------
  // Round-robin selection: first pending lane at or after ptr_q, with wrap.
  // ptr_q and the loop offset are both below LANES, so one conditional
  // subtraction brings the candidate back into range.
  // ---------------------------------------------------------------------------
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int i = 0; i < LANES; i++) begin
      cand = {1'b0, ptr_q} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(LANES)) begin
        cand = cand - (IDX_W+1)'(LANES);
      end
      if (!sel_found && pending_q[cand[IDX_W-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    load_vec = '0;
    if (state_q == ST_IDLE && sel_found) begin
      load_vec[sel_idx] = 1'b1;
    end
  end

  // After the last lane is served, the next search starts at lane 0.
  assign ptr_inc = (lane_q == IDX_W'(LANES-1)) ? '0 : lane_q + IDX_W'(1);

  // ---------------------------------------------------------------------------
  // Scanner FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      lane_q  <= '0;
      data_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (sel_found) begin
            lane_q  <= sel_idx;
            data_q  <= hold_q[sel_idx];
            state_q <= ST_PRESENT;
          end
        end
        ST_PRESENT: begin
          // lane_q and data_q are left alone here. New posts, including ones
          // to the presented lane, only go into the holding registers.
          if (out_ready_i) begin
            ptr_q   <= ptr_inc;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign out_valid_o = (state_q == ST_PRESENT);
  assign out_lane_o  = lane_q;
  assign out_data_o  = data_q;
  assign pending_o   = pending_q;
  assign overflow_o  = overflow_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_lane_flag_reader.sv
// -----------------------------------------------------------------------------
// tb_lane_flag_reader
//
// Directed bench for lane_flag_reader (LANES=4, PAYLOAD_W=8). Each expected
// output entry is pushed to exp_q as {lane, data} when the post is driven. A
// negedge monitor pops an entry on every output transfer and compares it with
// what the DUT presents.
// -----------------------------------------------------------------------------
module tb_lane_flag_reader;

  localparam int LANES     = 4;
  localparam int PAYLOAD_W = 8;
  localparam int IDX_W     = 2;

  // Clock and reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [LANES-1:0]           set_i;
  logic [LANES*PAYLOAD_W-1:0] set_data_i;
  logic                       out_valid_o;
  logic                       out_ready_i;
  logic [IDX_W-1:0]           out_lane_o;
  logic [PAYLOAD_W-1:0]       out_data_o;
  logic [LANES-1:0]           pending_o;
  logic [LANES-1:0]           overflow_o;
  logic                       clr_ovf_i;
  logic [0:0]                 state_o;

  lane_flag_reader #(.LANES(LANES), .PAYLOAD_W(PAYLOAD_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .set_i       (set_i),
    .set_data_i  (set_data_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_lane_o  (out_lane_o),
    .out_data_o  (out_data_o),
    .pending_o   (pending_o),
    .overflow_o  (overflow_o),
    .clr_ovf_i   (clr_ovf_i),
    .state_o     (state_o)
  );

  // Scoreboard
  logic [IDX_W+PAYLOAD_W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: valid & ready at the negedge means a transfer on the next
  // rising edge.
  always @(negedge clk) begin
    if (rst_n && out_valid_o === 1'b1 && out_ready_i === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $error("FAIL unexpected_output observed lane=%0d data=%0h expected=none",
               out_lane_o, out_data_o);
      end else begin
        logic [IDX_W+PAYLOAD_W-1:0] e;
        e = exp_q.pop_front();
        check("out_lane", 32'(out_lane_o), 32'(e[IDX_W+PAYLOAD_W-1:PAYLOAD_W]));
        check("out_data", 32'(out_data_o), 32'(e[PAYLOAD_W-1:0]));
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench did not finish");
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    set_i       = '0;
    set_data_i  = '0;
    out_ready_i = 1'b0;
    clr_ovf_i   = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic post(input logic [LANES-1:0] mask, input logic [31:0] data);
    set_i      = mask;
    set_data_i = data;
    tick();
    set_i      = '0;
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_valid"},    32'(out_valid_o), 32'h0);
    check({tag, "_lane"},     32'(out_lane_o),  32'h0);
    check({tag, "_data"},     32'(out_data_o),  32'h0);
    check({tag, "_pending"},  32'(pending_o),   32'h0);
    check({tag, "_overflow"}, 32'(overflow_o),  32'h0);
    check({tag, "_state"},    32'(state_o),     32'h0);
  endtask

  initial begin
    // ---- 1) reset values and single post with two-cycle latency
    do_reset();
    check_idle_zero("rst");
    out_ready_i = 1'b1;
    exp_q.push_back({2'd2, 8'hA5});
    post(4'b0100, 32'h00A5_0000);
    check("t1_pending_set", 32'(pending_o),   32'h4);
    check("t1_valid_early", 32'(out_valid_o), 32'h0);
    tick();
    check("t1_valid",       32'(out_valid_o), 32'h1);
    check("t1_lane",        32'(out_lane_o),  32'h2);
    check("t1_data",        32'(out_data_o),  32'hA5);
    check("t1_pending_clr", 32'(pending_o),   32'h0);
    tick();
    check("t1_valid_drop",  32'(out_valid_o), 32'h0);
    check("t1_drained",     32'(exp_q.size()), 32'h0);

    // ---- 2) all lanes at once: served 0..3, one entry every second cycle
    do_reset();
    out_ready_i = 1'b1;
    for (int k = 0; k < LANES; k++) exp_q.push_back({2'(k), 8'(8'h10 + k)});
    post(4'b1111, 32'h1312_1110);
    check("t2_pending", 32'(pending_o), 32'hF);
    for (int k = 0; k < LANES; k++) begin
      tick();
      check("t2_valid_hi", 32'(out_valid_o), 32'h1);
      check("t2_lane_seq", 32'(out_lane_o),  32'(k));
      tick();
      check("t2_valid_lo", 32'(out_valid_o), 32'h0);
    end
    check("t2_drained", 32'(exp_q.size()), 32'h0);

    // ---- 3) pointer at 2 after serving lane 1: lane 3 before lane 0
    do_reset();
    out_ready_i = 1'b1;
    exp_q.push_back({2'd1, 8'hB1});
    post(4'b0010, 32'h0000_B100);
    tick();
    tick();
    exp_q.push_back({2'd3, 8'hD0});
    exp_q.push_back({2'd0, 8'hC0});
    post(4'b1001, 32'hD000_00C0);
    tick();
    check("t3_first_lane", 32'(out_lane_o), 32'h3);
    tick();
    tick();
    check("t3_second_lane", 32'(out_lane_o), 32'h0);
    tick();
    check("t3_drained", 32'(exp_q.size()), 32'h0);

    // ---- 4) overflow on lane 1 while output is stalled, newest wins, clear
    do_reset();
    out_ready_i = 1'b0;
    exp_q.push_back({2'd0, 8'h40});
    post(4'b0001, 32'h0000_0040);
    tick();
    check("t4_busy_valid", 32'(out_valid_o), 32'h1);
    post(4'b0010, 32'h0000_1100);
    check("t4_no_ovf_yet", 32'(overflow_o), 32'h0);
    post(4'b0010, 32'h0000_2200);
    check("t4_overflow",   32'(overflow_o), 32'h2);
    check("t4_pending",    32'(pending_o),  32'h2);
    exp_q.push_back({2'd1, 8'h22});
    out_ready_i = 1'b1;
    tick();
    tick();
    check("t4_lane1",      32'(out_lane_o), 32'h1);
    check("t4_newest",     32'(out_data_o), 32'h22);
    tick();
    check("t4_ovf_sticky", 32'(overflow_o), 32'h2);
    clr_ovf_i = 1'b1;
    tick();
    clr_ovf_i = 1'b0;
    check("t4_ovf_clr",    32'(overflow_o), 32'h0);
    check("t4_drained",    32'(exp_q.size()), 32'h0);

    // ---- 5) post to the presented lane does not disturb the output
    do_reset();
    out_ready_i = 1'b0;
    exp_q.push_back({2'd0, 8'h33});
    post(4'b0001, 32'h0000_0033);
    tick();
    exp_q.push_back({2'd0, 8'h55});
    post(4'b0001, 32'h0000_0055);
    check("t5_hold_data",    32'(out_data_o), 32'h33);
    check("t5_hold_lane",    32'(out_lane_o), 32'h0);
    check("t5_pending",      32'(pending_o),  32'h1);
    check("t5_no_ovf",       32'(overflow_o), 32'h0);
    tick();
    check("t5_stall_data",   32'(out_data_o), 32'h33);
    out_ready_i = 1'b1;
    tick();
    check("t5_gap",          32'(out_valid_o), 32'h0);
    tick();
    check("t5_re_valid",     32'(out_valid_o), 32'h1);
    check("t5_re_data",      32'(out_data_o),  32'h55);
    tick();
    check("t5_no_ovf_end",   32'(overflow_o), 32'h0);
    check("t5_drained",      32'(exp_q.size()), 32'h0);

    // ---- 6) asynchronous reset while presenting
    do_reset();
    out_ready_i = 1'b0;
    post(4'b0100, 32'h0077_0000);
    tick();
    check("t6_valid_before", 32'(out_valid_o), 32'h1);
    post(4'b1000, 32'h8800_0000);
    post(4'b1000, 32'h9900_0000);
    check("t6_ovf_before",   32'(overflow_o), 32'h8);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_zero("t6_async");
    out_ready_i = 1'b1;
    #3;
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("t6_quiet_valid",   32'(out_valid_o), 32'h0);
      check("t6_quiet_pending", 32'(pending_o),   32'h0);
    end
    check("t6_drained", 32'(exp_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
